// File: rtl/dispatch_gen.sv
// dispatch_gen: synthetic packetised ready/valid traffic source.
// Emits fixed-length packets with sop/eop framing, LFSR payload and a
// per-packet priority sideband. A free-running LFSR throttles valid, and
// the source can stop by itself after a programmed packet count.
//
// Ports:
//   clk          sole clock
//   reset        asynchronous, active-high reset
//   i_enable     permits packet starts (sampled at packet boundaries)
//   o_valid      beat valid (registered)
//   i_ready      sink ready
//   o_data       {payload_lfsr[WIDTH-17:0], pkt_num[7:0], beat[7:0]}
//   o_sop/o_eop  first/last beat of packet, decoded from the beat counter
//   o_lp         per-packet priority bit
//   o_pkt_count  packets completed, wraps at 16'hFFFF
//   o_done       sticky, all NUM_PKTS packets sent
module dispatch_gen #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned NUM_PKTS   = 0,
  parameter logic [15:0] VALID_SEED = 16'hABED,
  parameter logic [31:0] DATA_SEED  = 32'hDEADBEEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_lp,
  output logic [15:0]      o_pkt_count,
  output logic             o_done
);

  localparam logic [7:0]  LAST_BEAT  = 8'(PKT_LEN - 1);
  localparam logic [15:0] NUM_PKTS_W = 16'(NUM_PKTS);
  localparam bit          LIMITED    = (NUM_PKTS != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

  // Priority bit derived from the payload LFSR value that opens a packet.
  function automatic logic lp_of(input logic [31:0] p);
    return (p[0] & p[1]) | (p[2] ^ p[3]);
  endfunction

  state_t      r_state;
  logic [15:0] r_vlfsr;
  logic [31:0] r_plfsr;
  logic [7:0]  r_pkt_num;
  logic [7:0]  r_beat;
  logic        r_lp;
  logic [15:0] r_pkt_count;
  logic        r_valid;
  logic        r_done;

  logic        w_t;
  logic        w_eop;
  logic        w_accept;
  logic        w_last_pkt;
  logic [15:0] w_vlfsr_next;
  logic [31:0] w_plfsr_next;

  assign w_t          = r_vlfsr[0];
  assign w_eop        = (r_beat == LAST_BEAT);
  assign w_accept     = r_valid & i_ready;
  assign w_vlfsr_next = {r_vlfsr[0] ^ r_vlfsr[2] ^ r_vlfsr[3] ^ r_vlfsr[5], r_vlfsr[15:1]};
  assign w_plfsr_next = {r_plfsr[0] ^ r_plfsr[10] ^ r_plfsr[30] ^ r_plfsr[31], r_plfsr[31:1]};
  // True while the packet in flight is the final one of a limited run.
  assign w_last_pkt   = LIMITED && ((r_pkt_count + 16'd1) == NUM_PKTS_W);

  // Datapath counters, LFSRs and the control FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_vlfsr     <= VALID_SEED;
      r_plfsr     <= DATA_SEED;
      r_pkt_num   <= 8'd0;
      r_beat      <= 8'd0;
      r_lp        <= lp_of(DATA_SEED);
      r_pkt_count <= 16'd0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_vlfsr <= w_vlfsr_next;

      if (w_accept) begin
        r_plfsr <= w_plfsr_next;
        if (w_eop) begin
          r_beat      <= 8'd0;
          r_pkt_num   <= r_pkt_num + 8'd1;
          r_pkt_count <= r_pkt_count + 16'd1;
          // Next packet's priority comes from the payload it will start with.
          r_lp        <= lp_of(w_plfsr_next);
        end else begin
          r_beat <= r_beat + 8'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (i_enable && !r_done) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Enable only matters between packets; mid-packet it is ignored.
          if ((r_beat == 8'd0) && !i_enable) begin
            r_state <= ST_IDLE;
          end else if (w_t) begin
            r_state <= ST_SEND;
            r_valid <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (w_eop && w_last_pkt) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_t && (!w_eop || i_enable)) begin
              r_state <= ST_SEND;
            end else begin
              r_state <= ST_WAIT;
              r_valid <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // A 16-bit bus carries only the packet and beat numbers.
  generate
    if (WIDTH > 16) begin : g_payload
      assign o_data = {r_plfsr[WIDTH-17:0], r_pkt_num, r_beat};
    end else begin : g_no_payload
      assign o_data = {r_pkt_num, r_beat};
    end
  endgenerate

  assign o_valid     = r_valid;
  assign o_sop       = (r_beat == 8'd0);
  assign o_eop       = w_eop;
  assign o_lp        = r_lp;
  assign o_pkt_count = r_pkt_count;
  assign o_done      = r_done;

endmodule

// File: tb/tb_dispatch_gen.sv
// Self-checking bench for dispatch_gen: expected beats are queued by the
// stimulus, and a negedge monitor per instance pops and compares them.
module tb_dispatch_gen;

  localparam logic [31:0] SEED = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_ready, a_valid, a_sop, a_eop, a_lp, a_done;
  logic [31:0] a_data;
  logic [15:0] a_pcnt;
  logic        b_rst, b_en, b_ready, b_valid, b_sop, b_eop, b_lp, b_done;
  logic [31:0] b_data;
  logic [15:0] b_pcnt;

  dispatch_gen #(.WIDTH(32), .PKT_LEN(4), .NUM_PKTS(0)) u_a (
    .clk(clk), .reset(a_rst), .i_enable(a_en), .o_valid(a_valid),
    .i_ready(a_ready), .o_data(a_data), .o_sop(a_sop), .o_eop(a_eop),
    .o_lp(a_lp), .o_pkt_count(a_pcnt), .o_done(a_done)
  );

  dispatch_gen #(.WIDTH(32), .PKT_LEN(3), .NUM_PKTS(2)) u_b (
    .clk(clk), .reset(b_rst), .i_enable(b_en), .o_valid(b_valid),
    .i_ready(b_ready), .o_data(b_data), .o_sop(b_sop), .o_eop(b_eop),
    .o_lp(b_lp), .o_pkt_count(b_pcnt), .o_done(b_done)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        lp;
  } beat_t;

  beat_t       qa[$];
  beat_t       qb[$];
  beat_t       ea, eb;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic [31:0] ma_p, mb_p;
  logic [7:0]  ma_pkt, mb_pkt;

  function automatic logic [31:0] pnext(input logic [31:0] p);
    return {p[0] ^ p[10] ^ p[30] ^ p[31], p[31:1]};
  endfunction

  function automatic logic lp_of(input logic [31:0] p);
    return (p[0] & p[1]) | (p[2] ^ p[3]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_a(input int npk);
    beat_t e;
    logic  lp;
    for (int p = 0; p < npk; p++) begin
      lp = lp_of(ma_p);
      for (int b = 0; b < 4; b++) begin
        e.data = {ma_p[15:0], ma_pkt, 8'(b)};
        e.sop  = (b == 0);
        e.eop  = (b == 3);
        e.lp   = lp;
        qa.push_back(e);
        ma_p = pnext(ma_p);
      end
      ma_pkt = ma_pkt + 8'd1;
    end
  endtask

  task automatic push_b(input int npk);
    beat_t e;
    logic  lp;
    for (int p = 0; p < npk; p++) begin
      lp = lp_of(mb_p);
      for (int b = 0; b < 3; b++) begin
        e.data = {mb_p[15:0], mb_pkt, 8'(b)};
        e.sop  = (b == 0);
        e.eop  = (b == 2);
        e.lp   = lp;
        qb.push_back(e);
        mb_p = pnext(mb_p);
      end
      mb_pkt = mb_pkt + 8'd1;
    end
  endtask

  // Poll after each rising edge until the accepted-beat count reaches target.
  task automatic wait_cnt(input bit sel_b, input int target, input string nm);
    int budget;
    budget = 400;
    while (((sel_b ? cnt_b : cnt_a) < target) && (budget > 0)) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check(nm, 32'(sel_b ? cnt_b : cnt_a), 32'(target));
  endtask

  task automatic wait_valid_a(input string nm);
    int budget;
    budget = 200;
    while (!a_valid && (budget > 0)) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check(nm, 32'(a_valid), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_valid"}, 32'(a_valid), 32'd0);
    check({tag, "_data"},  a_data, 32'hBEEF0000);
    check({tag, "_sop"},   32'(a_sop), 32'd1);
    check({tag, "_eop"},   32'(a_eop), 32'd0);
    check({tag, "_pcnt"},  32'(a_pcnt), 32'd0);
    check({tag, "_done"},  32'(a_done), 32'd0);
    check({tag, "_lp"},    32'(a_lp), 32'd1);
  endtask

  // Monitor A: a beat seen valid&&ready at negedge transfers on the next rising edge.
  always @(negedge clk) begin
    if (!a_rst && a_valid && a_ready) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_beat: got data %h want no beat at %0t", a_data, $time);
      end else begin
        ea = qa.pop_front();
        check("a_data", a_data, ea.data);
        check("a_sop", 32'(a_sop), 32'(ea.sop));
        check("a_eop", 32'(a_eop), 32'(ea.eop));
        check("a_lp", 32'(a_lp), 32'(ea.lp));
      end
      cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_valid && b_ready) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_beat: got data %h want no beat at %0t", b_data, $time);
      end else begin
        eb = qb.pop_front();
        check("b_data", b_data, eb.data);
        check("b_sop", 32'(b_sop), 32'(eb.sop));
        check("b_eop", 32'(b_eop), 32'(eb.eop));
        check("b_lp", 32'(b_lp), 32'(eb.lp));
      end
      cnt_b++;
    end
  end

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_ready = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_ready = 1'b0;
    ma_p = SEED; ma_pkt = 8'd0;
    mb_p = SEED; mb_pkt = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst0");
    check("b_rst_sop", 32'(b_sop), 32'd1);
    check("b_rst_eop", 32'(b_eop), 32'd0);
    check("b_rst_done", 32'(b_done), 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk);
    #1;

    // Enable drop after beat 1: packet still completes, then the source idles.
    push_a(1);
    a_ready = 1'b1;
    a_en    = 1'b1;
    @(posedge clk);
    #1;
    check("a_valid_latency", 32'(a_valid), 32'd0);
    wait_cnt(1'b0, 2, "a_p0_beats01");
    a_en = 1'b0;
    wait_cnt(1'b0, 4, "a_p0_beats");
    check("a_p0_pcnt", 32'(a_pcnt), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("a_idle_valid", 32'(a_valid), 32'd0);
    check("a_idle_count", 32'(cnt_a), 32'd4);

    // Backpressure: beat must hold for 10 cycles, then exactly one transfers.
    a_ready = 1'b0;
    push_a(2);
    a_en = 1'b1;
    wait_valid_a("a_p1_valid");
    check("a_resume_lo", {16'd0, a_data[15:0]}, 32'h0000_0100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("a_hold_valid", 32'(a_valid), 32'd1);
      check("a_hold_data", a_data, qa[0].data);
      check("a_hold_sop", 32'(a_sop), 32'(qa[0].sop));
      check("a_hold_eop", 32'(a_eop), 32'(qa[0].eop));
      check("a_hold_lp", 32'(a_lp), 32'(qa[0].lp));
    end
    a_ready = 1'b1;
    @(posedge clk);
    #1;
    a_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("a_one_beat", 32'(cnt_a), 32'd5);
    a_ready = 1'b1;
    wait_cnt(1'b0, 10, "a_p2_beats01");
    check("a_p2_pcnt", 32'(a_pcnt), 32'd2);

    // Reset mid-packet: everything returns to reset values, model restarts.
    a_rst = 1'b1;
    qa.delete();
    ma_p   = SEED;
    ma_pkt = 8'd0;
    #2;
    check_reset_a("rst1");
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    push_a(1);
    wait_valid_a("a_p3_valid");
    check("a_restart_lo", {16'd0, a_data[15:0]}, 32'h0000_0000);
    check("a_restart_sop", 32'(a_sop), 32'd1);
    wait_cnt(1'b0, 11, "a_p3_beat0");
    a_en = 1'b0;
    wait_cnt(1'b0, 14, "a_p3_beats");
    check("a_p3_pcnt", 32'(a_pcnt), 32'd1);

    // Limited run: two packets of three beats, then sticky done.
    push_b(2);
    b_ready = 1'b1;
    b_en    = 1'b1;
    wait_cnt(1'b1, 6, "b_beats");
    check("b_done_rise", 32'(b_done), 32'd1);
    check("b_valid_fall", 32'(b_valid), 32'd0);
    check("b_pcnt", 32'(b_pcnt), 32'd2);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("b_stay_valid", 32'(b_valid), 32'd0);
      check("b_stay_done", 32'(b_done), 32'd1);
    end
    check("b_total", 32'(cnt_b), 32'd6);
    check("a_total", 32'(cnt_a), 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
